// File: rtl/hash_table.sv
// Shared types and sizes for the hash-table pipeline stages.
package hash_table;

    localparam int BUCKET_WIDTH     = 8;
    localparam int HEAD_PTR_WIDTH   = 10;
    localparam int KEY_WIDTH        = 32;
    localparam int VALUE_WIDTH      = 16;
    localparam int HEAD_TABLE_DEPTH = 2**BUCKET_WIDTH;

    typedef enum logic [1:0] {
        CMD_SEARCH = 2'd0,
        CMD_INSERT = 2'd1,
        CMD_DELETE = 2'd2,
        CMD_NOP    = 2'd3
    } ht_cmd_t;

    // One head-pointer RAM word: chain head pointer plus its valid flag.
    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      ptr_val;
    } head_ram_data_t;

    // Pipeline payload (69 bits).
    typedef struct packed {
        ht_cmd_t                   cmd;
        logic [KEY_WIDTH-1:0]      key;
        logic [VALUE_WIDTH-1:0]    value;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_pdata_t;

    typedef enum logic {
        HT_INIT = 1'b0,
        HT_RUN  = 1'b1
    } head_table_state_t;

endpackage

// File: rtl/head_table_ram.sv
// Simple dual-port head-pointer RAM: registered read with clock enable,
// old data returned on read-during-write, contents not reset.
module head_table_ram
    import hash_table::*;
(
    input  logic                    clk_i,
    input  logic                    wr_en_i,
    input  logic [BUCKET_WIDTH-1:0] wr_addr_i,
    input  head_ram_data_t          wr_data_i,
    input  logic                    rd_en_i,
    input  logic [BUCKET_WIDTH-1:0] rd_addr_i,
    output head_ram_data_t          rd_data_o
);

    head_ram_data_t mem [HEAD_TABLE_DEPTH];
    head_ram_data_t rd_data_q;

    // Write port and enabled registered read; the read sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/head_table.sv
// Head-table pipeline stage: looks up the chain head for each bucket,
// clears the head RAM after reset and forwards writes from the data-table
// stage to the RAM, bypassing them into items already in flight.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds valid and payload stable until that edge, and
// ready never depends on the same port's valid.
module head_table
    import hash_table::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  ht_pdata_t               pdata_in_i,
    input  logic                    pdata_in_valid_i,
    output logic                    pdata_in_ready_o,
    output ht_pdata_t               pdata_out_o,
    output logic                    pdata_out_valid_o,
    input  logic                    pdata_out_ready_i,
    input  logic [BUCKET_WIDTH-1:0] head_wr_addr_i,
    input  head_ram_data_t          head_wr_data_i,
    input  logic                    head_wr_en_i,
    output logic                    init_done_o
);

    head_table_state_t       state_q, state_d;
    logic [BUCKET_WIDTH-1:0] clear_cnt_q, clear_cnt_d;

    logic                    s1_valid_q, s1_valid_d;
    ht_pdata_t               s1_data_q, s1_data_d;
    logic                    byp_val_q, byp_val_d;
    head_ram_data_t          byp_data_q, byp_data_d;

    logic                    s2_valid_q, s2_valid_d;
    ht_pdata_t               s2_data_q, s2_data_d;

    logic                    run;
    logic                    en;
    logic                    in_xfer;
    logic                    wr_run;
    head_ram_data_t          s1_head;

    logic                    ram_wr_en;
    logic [BUCKET_WIDTH-1:0] ram_wr_addr;
    head_ram_data_t          ram_wr_data;
    head_ram_data_t          ram_q;

    assign run              = (state_q == HT_RUN);
    assign en               = !s2_valid_q || pdata_out_ready_i;
    assign pdata_in_ready_o = en && run;
    assign in_xfer          = pdata_in_valid_i && pdata_in_ready_o;
    // Upstream writes only count once the clear sweep has finished.
    assign wr_run           = head_wr_en_i && run;

    // Clear sweep: one address per cycle, stop on the last bucket without wrapping.
    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        if (state_q == HT_INIT) begin
            if (clear_cnt_q == BUCKET_WIDTH'(HEAD_TABLE_DEPTH - 1)) begin
                state_d = HT_RUN;
            end else begin
                clear_cnt_d = clear_cnt_q + 1'b1;
            end
        end
    end

    // RAM write port is owned by the sweep during INIT, by upstream during RUN.
    always_comb begin
        if (run) begin
            ram_wr_en   = head_wr_en_i;
            ram_wr_addr = head_wr_addr_i;
            ram_wr_data = head_wr_data_i;
        end else begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clear_cnt_q;
            ram_wr_data = '0;
        end
    end

    head_table_ram u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_data_i (ram_wr_data),
        .rd_en_i   (en),
        .rd_addr_i (pdata_in_i.bucket),
        .rd_data_o (ram_q)
    );

    // Pipeline advance and bypass: newest matching write beats the stale RAM word.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        byp_val_d  = byp_val_q;
        byp_data_d = byp_data_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;

        if (wr_run && (head_wr_addr_i == s1_data_q.bucket)) begin
            s1_head = head_wr_data_i;
        end else if (byp_val_q) begin
            s1_head = byp_data_q;
        end else begin
            s1_head = ram_q;
        end

        if (en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d              = s1_data_q;
                s2_data_d.head_ptr     = s1_head.ptr;
                s2_data_d.head_ptr_val = s1_head.ptr_val;
            end
            s1_valid_d = in_xfer;
            if (in_xfer) begin
                s1_data_d  = pdata_in_i;
                byp_val_d  = wr_run && (head_wr_addr_i == pdata_in_i.bucket);
                byp_data_d = head_wr_data_i;
            end
        end else begin
            if (wr_run && (head_wr_addr_i == s1_data_q.bucket)) begin
                byp_val_d  = 1'b1;
                byp_data_d = head_wr_data_i;
            end
            if (s2_valid_q && wr_run && (head_wr_addr_i == s2_data_q.bucket)) begin
                s2_data_d.head_ptr     = head_wr_data_i.ptr;
                s2_data_d.head_ptr_val = head_wr_data_i.ptr_val;
            end
        end
    end

    // State, sweep counter and pipeline registers; reset drops in-flight items.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= HT_INIT;
            clear_cnt_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            byp_val_q   <= 1'b0;
            byp_data_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            byp_val_q   <= byp_val_d;
            byp_data_q  <= byp_data_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
        end
    end

    assign pdata_out_o       = s2_data_q;
    assign pdata_out_valid_o = s2_valid_q;
    assign init_done_o       = run;

endmodule

// File: tb/tb_head_table.sv
// Bench for head_table: directed hazard table, backpressure and reset
// sequences, plus random traffic checked against a bucket-array model.
`timescale 1ns/1ps
module tb_head_table;
    import hash_table::*;

    logic                    clk = 1'b0;
    logic                    rst;
    ht_pdata_t               pin;
    logic                    pin_valid;
    logic                    pin_ready;
    ht_pdata_t               pout;
    logic                    pout_valid;
    logic                    pout_ready;
    logic [BUCKET_WIDTH-1:0] wr_addr;
    head_ram_data_t          wr_data;
    logic                    wr_en;
    logic                    init_done;

    always #5 clk = ~clk;

    head_table dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .pdata_in_i        (pin),
        .pdata_in_valid_i  (pin_valid),
        .pdata_in_ready_o  (pin_ready),
        .pdata_out_o       (pout),
        .pdata_out_valid_o (pout_valid),
        .pdata_out_ready_i (pout_ready),
        .head_wr_addr_i    (wr_addr),
        .head_wr_data_i    (wr_data),
        .head_wr_en_i      (wr_en),
        .init_done_o       (init_done)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic head_ram_data_t hd(input logic [9:0] p, input logic v);
        head_ram_data_t h;
        h.ptr     = p;
        h.ptr_val = v;
        return h;
    endfunction

    function automatic ht_pdata_t mk_item(input logic [7:0] b);
        ht_pdata_t p;
        p.cmd          = ht_cmd_t'(2'($urandom_range(0, 3)));
        p.key          = $urandom;
        p.value        = 16'($urandom);
        p.bucket       = b;
        p.head_ptr     = 10'($urandom);
        p.head_ptr_val = 1'($urandom);
        return p;
    endfunction

    // Reference model: bucket array of current heads and the in-order list of
    // accepted items. An output on a given cycle must show every write from
    // earlier cycles, so the compare happens before this cycle's write lands.
    head_ram_data_t model_mem [HEAD_TABLE_DEPTH];
    ht_pdata_t      exp_q [$];
    ht_pdata_t      mon_exp;
    int             out_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            foreach (model_mem[i]) model_mem[i] = '0;
            exp_q.delete();
        end else begin
            if (pout_valid) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL spurious_out: got %0h expected no output", pout);
                end else begin
                    mon_exp              = exp_q[0];
                    mon_exp.head_ptr     = model_mem[mon_exp.bucket].ptr;
                    mon_exp.head_ptr_val = model_mem[mon_exp.bucket].ptr_val;
                    if (pout_ready) begin
                        check("out_xfer", pout, mon_exp);
                        void'(exp_q.pop_front());
                        out_cnt++;
                    end else begin
                        check("out_hold", pout, mon_exp);
                    end
                end
            end
            if (pin_valid && pin_ready) exp_q.push_back(pin);
            if (wr_en) model_mem[wr_addr] = wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done && cycles < 400) begin
            tick();
            cycles++;
        end
    endtask

    task automatic do_write(input logic [7:0] a, input head_ram_data_t d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic send(input ht_pdata_t p);
        bit ok;
        int g;
        ok = 1'b0;
        g  = 0;
        pin       = p;
        pin_valid = 1'b1;
        while (!ok && g < 50) begin
            @(negedge clk);
            ok = pin_ready;
            @(posedge clk);
            #1;
            g++;
        end
        pin_valid = 1'b0;
        check("send_accept", 69'(ok), 69'(1));
    endtask

    // Waits for the next output transfer and returns its payload.
    task automatic wait_out(output ht_pdata_t o, output bit seen);
        int g;
        seen = 1'b0;
        g    = 0;
        o    = '0;
        while (!seen && g < 30) begin
            @(negedge clk);
            if (pout_valid && pout_ready) begin
                seen = 1'b1;
                o    = pout;
            end
            @(posedge clk);
            #1;
            g++;
        end
    endtask

    typedef struct {
        logic [7:0]     bucket;
        head_ram_data_t pre;
        int             mode;   // 0 write at issue, 1 write next cycle, 2 write in stall, 3 no write
        head_ram_data_t wr;
        head_ram_data_t exp;
    } hz_vec_t;

    hz_vec_t hz [6];

    task automatic run_hazard(input hz_vec_t v);
        bit        ok;
        bit        seen;
        ht_pdata_t o;
        do_write(v.bucket, v.pre);
        tick();
        tick();
        pout_ready = (v.mode != 2);
        pin        = mk_item(v.bucket);
        pin_valid  = 1'b1;
        if (v.mode == 0) begin
            wr_addr = v.bucket;
            wr_data = v.wr;
            wr_en   = 1'b1;
        end
        @(negedge clk);
        ok = pin_ready;
        @(posedge clk);
        #1;
        pin_valid = 1'b0;
        wr_en     = 1'b0;
        check("hz_issue", 69'(ok), 69'(1));
        if (v.mode == 1) do_write(v.bucket, v.wr);
        if (v.mode == 2) begin
            tick();
            tick();
            do_write(v.bucket, v.wr);
            tick();
            pout_ready = 1'b1;
        end
        wait_out(o, seen);
        check("hz_seen", 69'(seen), 69'(1));
        check("hz_head", 69'({o.head_ptr, o.head_ptr_val}), 69'(v.exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int        cyc;
        int        idx;
        int        out_start;
        bit        seen;
        bit        acc;
        ht_pdata_t o;
        ht_pdata_t cur;

        hz[0] = '{8'h05, hd(10'h100, 1'b1), 0, hd(10'h007, 1'b1), hd(10'h007, 1'b1)};
        hz[1] = '{8'h05, hd(10'h100, 1'b1), 1, hd(10'h007, 1'b1), hd(10'h007, 1'b1)};
        hz[2] = '{8'h05, hd(10'h100, 1'b1), 2, hd(10'h007, 1'b1), hd(10'h007, 1'b1)};
        hz[3] = '{8'h40, hd(10'h2AA, 1'b1), 0, hd(10'h000, 1'b0), hd(10'h000, 1'b0)};
        hz[4] = '{8'h41, hd(10'h123, 1'b1), 3, hd(10'h000, 1'b0), hd(10'h123, 1'b1)};
        hz[5] = '{8'h42, hd(10'h3FF, 1'b1), 2, hd(10'h001, 1'b1), hd(10'h001, 1'b1)};

        rst        = 1'b1;
        pin        = '0;
        pin_valid  = 1'b0;
        pout_ready = 1'b1;
        wr_addr    = '0;
        wr_data    = '0;
        wr_en      = 1'b0;

        // Reset values, then the clear sweep length.
        repeat (3) tick();
        check("rst_out_valid", 69'(pout_valid), 69'(0));
        check("rst_in_ready", 69'(pin_ready), 69'(0));
        check("rst_init_done", 69'(init_done), 69'(0));
        check("rst_out_data", pout, 69'(0));
        rst = 1'b0;
        wait_init(cyc);
        check("init_cycles", 69'(cyc), 69'(256));

        // Cleared table reads back empty heads.
        for (int i = 0; i < 4; i++) send(mk_item(8'($urandom_range(0, 255))));
        repeat (4) tick();

        // Write then search: 2-cycle latency and the written head.
        do_write(8'h12, hd(10'h03A, 1'b1));
        repeat (5) tick();
        cur     = mk_item(8'h12);
        cur.cmd = CMD_SEARCH;
        send(cur);
        idx = 1;
        while (!pout_valid && idx < 10) begin
            tick();
            idx++;
        end
        check("search_latency", 69'(idx), 69'(2));
        check("search_ptr", 69'(pout.head_ptr), 69'(10'h03A));
        check("search_val", 69'(pout.head_ptr_val), 69'(1));
        tick();

        // Read/write hazard table.
        for (int i = 0; i < 6; i++) run_hazard(hz[i]);

        // Backpressure: 10 back-to-back inputs, output ready pattern 1,0,0.
        out_start = out_cnt;
        idx       = 0;
        cyc       = 0;
        cur       = mk_item(8'd0);
        while ((idx < 10 || out_cnt - out_start < 10) && cyc < 100) begin
            pout_ready = (cyc % 3 == 0);
            pin        = cur;
            pin_valid  = (idx < 10);
            @(negedge clk);
            acc = pin_valid && pin_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                cur = mk_item(8'(idx));
            end
            cyc++;
        end
        pin_valid  = 1'b0;
        pout_ready = 1'b1;
        check("bp_out_count", 69'(out_cnt - out_start), 69'(10));

        // Random traffic on a narrow bucket range to provoke hazards.
        acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            pout_ready = ($urandom_range(0, 3) != 0);
            if (!pin_valid || acc) begin
                pin       = mk_item(8'($urandom_range(0, 15)));
                pin_valid = 1'($urandom_range(0, 1));
            end
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 8'($urandom_range(0, 15));
            wr_data = hd(10'($urandom), 1'($urandom));
            @(negedge clk);
            acc = pin_valid && pin_ready;
            @(posedge clk);
            #1;
        end
        pin_valid  = 1'b0;
        wr_en      = 1'b0;
        pout_ready = 1'b1;
        repeat (8) tick();
        check("rand_drain", 69'(exp_q.size()), 69'(0));

        // Reset with both stages full.
        do_write(8'h12, hd(10'h03A, 1'b1));
        pout_ready = 1'b0;
        send(mk_item(8'h12));
        send(mk_item(8'h13));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 69'(pout_valid), 69'(0));
        check("mid_rst_out_data", pout, 69'(0));
        check("mid_rst_in_ready", 69'(pin_ready), 69'(0));
        check("mid_rst_init_done", 69'(init_done), 69'(0));
        tick();
        rst        = 1'b0;
        pout_ready = 1'b1;
        wait_init(cyc);
        check("reinit_cycles", 69'(cyc), 69'(256));
        send(mk_item(8'h12));
        wait_out(o, seen);
        check("reinit_seen", 69'(seen), 69'(1));
        check("reinit_val", 69'(o.head_ptr_val), 69'(0));
        repeat (3) tick();
        check("final_drain", 69'(exp_q.size()), 69'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
